// File: rtl/ccff_frame_loader.sv
// ---------------------------------------------------------------------------
// ccff_frame_loader
//
// Configuration-chain loader for a tile's TGATE routing/LUT mux selects.
// Bitstream words arrive over a valid/ready handshake. Each word is shifted
// MSB first into a NUM_BITS shadow chain. When the frame is complete, the
// whole chain is committed to mem_out/mem_outb in one cycle, so the mux
// selects never see partially programmed values.
//
// Ports:
//   prog_clk   in   programming clock
//   pReset_n   in   synchronous, active-low reset
//   cfg_start  in   one-cycle pulse that begins a new frame (IDLE/DONE only)
//   cfg_word   in   bitstream word, MSB shifted first
//   cfg_valid  in   cfg_word is valid
//   cfg_ready  out  loader can accept a word (LOAD state)
//   mem_out    out  committed configuration (TGATE sel)
//   mem_outb   out  ~mem_out (TGATE selb)
//   ccff_tail  out  last chain bit, serial stream to the next tile
//   busy       out  frame in progress (LOAD, SHIFT or COMMIT)
//   done       out  frame committed; sticky until the next cfg_start
//   err        out  sticky protocol error (word offered in IDLE or DONE)
// ---------------------------------------------------------------------------
module ccff_frame_loader #(
    parameter int NUM_BITS = 64,
    parameter int WORD_W   = 8
) (
    input  logic                prog_clk,
    input  logic                pReset_n,
    input  logic                cfg_start,
    input  logic [WORD_W-1:0]   cfg_word,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    output logic [NUM_BITS-1:0] mem_out,
    output logic [NUM_BITS-1:0] mem_outb,
    output logic                ccff_tail,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int CNT_W = $clog2(NUM_BITS + 1);
    localparam int K_W   = $clog2(WORD_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_COMMIT,
        S_DONE
    } state_e;

    state_e              state_q;
    logic [NUM_BITS-1:0] chain_q;
    logic [NUM_BITS-1:0] mem_out_q;
    logic [WORD_W-1:0]   shreg_q;
    logic [CNT_W-1:0]    bits_done_q;
    logic [K_W-1:0]      k_left_q;
    logic                done_q;
    logic                err_q;

    logic [NUM_BITS-1:0] chain_shifted;
    logic [K_W-1:0]      k_first;
    logic                last_bit;

    // A one-bit chain has no lower slice to keep; it simply takes the new bit.
    generate
        if (NUM_BITS == 1) begin : g_chain_single
            assign chain_shifted = shreg_q[WORD_W-1];
        end else begin : g_chain_multi
            assign chain_shifted = {chain_q[NUM_BITS-2:0], shreg_q[WORD_W-1]};
        end
    endgenerate

    // Bits to take from the word being accepted: a full word, or only the
    // top MSBs when fewer than WORD_W bits of the frame remain.
    always_comb begin
        int remaining;
        remaining = NUM_BITS - int'(bits_done_q);
        k_first   = K_W'(WORD_W);
        if (remaining < WORD_W) begin
            k_first = K_W'(remaining);
        end
    end

    // The shift about to happen fills the final chain position.
    assign last_bit = (bits_done_q == CNT_W'(NUM_BITS - 1));

    always_ff @(posedge prog_clk) begin
        // NOTE: the shadow chain and mem_out are ordinary flops, not a RAM,
        // so they are cleared by reset like every other register here.
        if (!pReset_n) begin
            state_q     <= S_IDLE;
            chain_q     <= '0;
            mem_out_q   <= '0;
            shreg_q     <= '0;
            bits_done_q <= '0;
            k_left_q    <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch
            // below reads the pre-edge value of each register.
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (cfg_start) begin
                        state_q     <= S_LOAD;
                        bits_done_q <= '0;
                        done_q      <= 1'b0;
                        err_q       <= 1'b0;
                    end else if (cfg_valid) begin
                        // Stray word: dropped, flagged until the next frame.
                        err_q <= 1'b1;
                    end
                end

                S_LOAD: begin
                    if (cfg_valid) begin
                        shreg_q  <= cfg_word;
                        k_left_q <= k_first;
                        state_q  <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    chain_q     <= chain_shifted;
                    shreg_q     <= shreg_q << 1;
                    bits_done_q <= bits_done_q + CNT_W'(1);
                    k_left_q    <= k_left_q - K_W'(1);
                    if (last_bit) begin
                        state_q <= S_COMMIT;
                    end else if (k_left_q == K_W'(1)) begin
                        state_q <= S_LOAD;
                    end
                end

                S_COMMIT: begin
                    mem_out_q <= chain_q;
                    done_q    <= 1'b1;
                    state_q   <= S_DONE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cfg_ready = (state_q == S_LOAD);
    assign busy      = (state_q == S_LOAD) || (state_q == S_SHIFT) || (state_q == S_COMMIT);
    assign done      = done_q;
    assign err       = err_q;
    assign mem_out   = mem_out_q;
    assign mem_outb  = ~mem_out_q;
    assign ccff_tail = chain_q[NUM_BITS-1];

endmodule

// File: tb/tb_ccff_frame_loader.sv
// ---------------------------------------------------------------------------
// tb_ccff_frame_loader
//
// Bench for ccff_frame_loader. One 64/8 instance carries the main frame
// traffic through a scoreboard of golden frames; an 8/8 and a 12/8 instance
// cover the single-word and partial-last-word cases. Inputs change and
// outputs are sampled on the falling edge of prog_clk.
// ---------------------------------------------------------------------------
module tb_ccff_frame_loader;

    logic prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    logic pReset_n;

    // 64/8 instance
    logic        cfg_start, cfg_valid, cfg_ready, ccff_tail, busy, done, err;
    logic [7:0]  cfg_word;
    logic [63:0] mem_out, mem_outb;

    // 8/8 instance
    logic        s8, v8, r8, t8, b8, d8, e8;
    logic [7:0]  w8, m8, mb8;

    // 12/8 instance
    logic        s12, v12, r12, t12, b12, d12, e12;
    logic [7:0]  w12;
    logic [11:0] m12, mb12;

    ccff_frame_loader #(.NUM_BITS(64), .WORD_W(8)) dut (
        .prog_clk (prog_clk), .pReset_n (pReset_n), .cfg_start (cfg_start),
        .cfg_word (cfg_word), .cfg_valid (cfg_valid), .cfg_ready (cfg_ready),
        .mem_out (mem_out), .mem_outb (mem_outb), .ccff_tail (ccff_tail),
        .busy (busy), .done (done), .err (err)
    );

    ccff_frame_loader #(.NUM_BITS(8), .WORD_W(8)) dut8 (
        .prog_clk (prog_clk), .pReset_n (pReset_n), .cfg_start (s8),
        .cfg_word (w8), .cfg_valid (v8), .cfg_ready (r8),
        .mem_out (m8), .mem_outb (mb8), .ccff_tail (t8),
        .busy (b8), .done (d8), .err (e8)
    );

    ccff_frame_loader #(.NUM_BITS(12), .WORD_W(8)) dut12 (
        .prog_clk (prog_clk), .pReset_n (pReset_n), .cfg_start (s12),
        .cfg_word (w12), .cfg_valid (v12), .cfg_ready (r12),
        .mem_out (m12), .mem_outb (mb12), .ccff_tail (t12),
        .busy (b12), .done (d12), .err (e12)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] sb_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Runs one 64/8 frame. The golden frame goes onto the scoreboard when
    // the frame is started and is compared when done rises.
    task automatic run_frame(input logic [7:0] w [8], input bit rnd_valid, input string tag);
        logic [63:0] golden;
        logic [63:0] old_mem;
        logic [63:0] exp;
        int          idx;
        int          cyc;
        bit          accept;

        golden = '0;
        for (int i = 0; i < 8; i++) golden = {golden[55:0], w[i]};
        old_mem = mem_out;

        @(negedge prog_clk);
        cfg_start = 1'b1;
        cfg_valid = 1'b0;
        sb_q.push_back(golden);
        @(negedge prog_clk);
        cfg_start = 1'b0;
        check({tag, " err cleared"}, 64'(err), 64'd0);
        check({tag, " done cleared"}, 64'(done), 64'd0);
        check({tag, " busy"}, 64'(busy), 64'd1);

        cyc = 1;
        idx = 0;
        while (!done && cyc < 400) begin
            if (idx < 8) begin
                cfg_word  = w[idx];
                cfg_valid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            end else begin
                cfg_valid = 1'b0;
            end
            accept = cfg_ready && cfg_valid;
            check({tag, " mem_out holds"}, mem_out, old_mem);
            @(negedge prog_clk);
            cyc++;
            if (accept) idx++;
        end
        cfg_valid = 1'b0;

        check({tag, " done seen"}, 64'(done), 64'd1);
        check({tag, " words consumed"}, 64'(idx), 64'd8);
        if (!rnd_valid) check({tag, " latency"}, 64'(cyc), 64'd74);

        if (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            check({tag, " mem_out"}, mem_out, exp);
            check({tag, " mem_outb"}, mem_outb, ~exp);
            check({tag, " ccff_tail"}, 64'(ccff_tail), 64'(exp[63]));
        end else begin
            check({tag, " scoreboard empty"}, 64'd1, 64'd0);
        end
    endtask

    initial begin
        logic [7:0]  w [8];
        logic [63:0] frame;
        int          cyc, idx8, idx12, c8, c12;
        bit          a8, a12;

        pReset_n  = 1'b0;
        cfg_start = 1'b0; cfg_valid = 1'b0; cfg_word = '0;
        s8  = 1'b0; v8  = 1'b0; w8  = '0;
        s12 = 1'b0; v12 = 1'b0; w12 = '0;
        repeat (3) @(negedge prog_clk);

        check("reset cfg_ready", 64'(cfg_ready), 64'd0);
        check("reset busy",      64'(busy),      64'd0);
        check("reset done",      64'(done),      64'd0);
        check("reset err",       64'(err),       64'd0);
        check("reset mem_out",   mem_out,        64'd0);
        check("reset mem_outb",  mem_outb,       '1);
        check("reset ccff_tail", 64'(ccff_tail), 64'd0);
        pReset_n = 1'b1;

        // Single-word frame (8/8) and partial-last-word frame (12/8).
        @(negedge prog_clk);
        s8 = 1'b1; s12 = 1'b1;
        @(negedge prog_clk);
        s8 = 1'b0; s12 = 1'b0;
        cyc = 1; idx8 = 0; idx12 = 0; c8 = 0; c12 = 0;
        while ((c8 == 0 || c12 == 0) && cyc < 100) begin
            v8  = (idx8 < 1);
            w8  = 8'hA5;
            v12 = (idx12 < 2);
            w12 = (idx12 == 0) ? 8'hAB : 8'hCD;
            a8  = r8 && v8;
            a12 = r12 && v12;
            if (c12 == 0) check("12/8 mem_out holds", 64'(m12), 64'd0);
            @(negedge prog_clk);
            cyc++;
            if (a8)  idx8++;
            if (a12) idx12++;
            if (d8  && c8  == 0) c8  = cyc;
            if (d12 && c12 == 0) c12 = cyc;
        end
        v8 = 1'b0; v12 = 1'b0;
        check("8/8 mem_out",   64'(m8),   64'hA5);
        check("8/8 mem_outb",  64'(mb8),  64'h5A);
        check("8/8 latency",   64'(c8),   64'd11);
        check("8/8 err",       64'(e8),   64'd0);
        check("12/8 mem_out",  64'(m12),  64'hABC);
        check("12/8 mem_outb", 64'(mb12), 64'h543);
        check("12/8 latency",  64'(c12),  64'd16);
        check("12/8 err",      64'(e12),  64'd0);

        // Frame of words 0x01..0x08 with cfg_valid held high.
        for (int i = 0; i < 8; i++) w[i] = 8'(i + 1);
        run_frame(w, 1'b0, "seq");
        check("seq golden", mem_out, 64'h0102030405060708);
        frame = mem_out;

        // Stray word while DONE: flagged, dropped, mem_out untouched.
        @(negedge prog_clk);
        cfg_word  = 8'hFF;
        cfg_valid = 1'b1;
        @(negedge prog_clk);
        cfg_valid = 1'b0;
        check("stray err",     64'(err),  64'd1);
        check("stray mem_out", mem_out,   frame);
        check("stray done",    64'(done), 64'd1);
        @(negedge prog_clk);
        check("stray err sticky", 64'(err), 64'd1);

        // Reload from DONE with random data and a randomly gapped cfg_valid.
        for (int i = 0; i < 8; i++) w[i] = 8'($urandom);
        run_frame(w, 1'b1, "rnd");

        // First frame bit is 1, so ccff_tail must show it after 64 shifts.
        for (int i = 0; i < 8; i++) w[i] = 8'h80 | 8'($urandom);
        run_frame(w, 1'b0, "msb");

        // Reset pulse in the middle of SHIFT.
        @(negedge prog_clk);
        cfg_start = 1'b1;
        @(negedge prog_clk);
        cfg_start = 1'b0;
        cfg_word  = 8'hFF;
        cfg_valid = 1'b1;
        @(negedge prog_clk);
        cfg_valid = 1'b0;
        repeat (3) @(negedge prog_clk);
        check("mid-shift busy", 64'(busy), 64'd1);
        pReset_n = 1'b0;
        @(negedge prog_clk);
        pReset_n = 1'b1;
        check("mid reset cfg_ready", 64'(cfg_ready), 64'd0);
        check("mid reset busy",      64'(busy),      64'd0);
        check("mid reset done",      64'(done),      64'd0);
        check("mid reset err",       64'(err),       64'd0);
        check("mid reset mem_out",   mem_out,        64'd0);
        check("mid reset mem_outb",  mem_outb,       '1);
        check("mid reset ccff_tail", 64'(ccff_tail), 64'd0);
        check("mid reset 8/8 mem_out", 64'(m8), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
